// File: rtl/cache_bus_pkg.sv
// Shared bus1 definitions: bus-size constants, command codes and frontend FSM states.
package cache_bus_pkg;

  localparam int unsigned BUS1_ADDR_W   = 14;
  localparam int unsigned BUS1_OFFSET_W = 4;
  localparam int unsigned BUS1_DATA_W   = 16;
  localparam int unsigned BUS1_CTRL_W   = 3;
  localparam int unsigned LINE_BYTES    = 16;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_READ8    = 3'd1,
    CMD_READ16   = 3'd2,
    CMD_READ32   = 3'd3,
    CMD_INV_LINE = 3'd4,
    CMD_WRITE8   = 3'd5,
    CMD_WRITE16  = 3'd6,
    CMD_WRITE32  = 3'd7
  } cmd_e;

  // Slave-driven response code shares its encoding with WRITE32.
  localparam logic [2:0] CMD_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_REQ,
    ST_WAIT,
    ST_RESP1,
    ST_RESP2,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/cache_bus1_frontend.sv
// Bus1 slave frontend: collects a two-cycle bus command, hands it to the cache core,
// and returns the core's completion as one or two RESPONSE beats.
module cache_bus1_frontend
  import cache_bus_pkg::*;
#(
  parameter int unsigned ADDR1_W  = BUS1_ADDR_W,
  parameter int unsigned OFFSET_W = BUS1_OFFSET_W,
  parameter int unsigned DATA1_W  = BUS1_DATA_W,
  parameter int unsigned CTR1_W   = BUS1_CTRL_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR1_W-1:0]          a1_in,
  input  logic [DATA1_W-1:0]          d1_in,
  input  logic [CTR1_W-1:0]           c1_in,
  output logic [DATA1_W-1:0]          d1_out,
  output logic                        d1_oe,
  output logic [CTR1_W-1:0]           c1_out,
  output logic                        c1_oe,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [CTR1_W-1:0]           req_cmd,
  output logic [ADDR1_W+OFFSET_W-1:0] req_addr,
  output logic [2*DATA1_W-1:0]        req_wdata,
  input  logic                        resp_valid,
  input  logic [2*DATA1_W-1:0]        resp_rdata
);

  localparam int unsigned WDATA_W = 2 * DATA1_W;

  state_e               state_q, state_d;
  logic [CTR1_W-1:0]    cmd_q, cmd_d;
  logic [ADDR1_W-1:0]   tag_q, tag_d;
  logic [OFFSET_W-1:0]  off_q, off_d;
  logic [DATA1_W-1:0]   wlo_q, wlo_d;
  logic [DATA1_W-1:0]   whi_q, whi_d;
  logic [WDATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA1_W-1:0]   d1_out_d;
  logic                 d1_oe_d;
  logic [CTR1_W-1:0]    c1_out_d;
  logic                 c1_oe_d;
  logic                 req_valid_d;
  logic                 cmd_is_read;
  logic                 in_resp_d;

  assign cmd_is_read = (cmd_q == CTR1_W'(CMD_READ8))  ||
                       (cmd_q == CTR1_W'(CMD_READ16)) ||
                       (cmd_q == CTR1_W'(CMD_READ32));

  // Next-state, latched-request and next-output computation.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tag_d    = tag_q;
    off_d    = off_q;
    wlo_d    = wlo_q;
    whi_d    = whi_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (c1_in == CTR1_W'(CMD_INV_LINE)) begin
          cmd_d   = c1_in;
          tag_d   = a1_in;
          off_d   = '0;
          wlo_d   = '0;
          whi_d   = '0;
          state_d = ST_REQ;
        end else if (c1_in != CTR1_W'(CMD_NOP)) begin
          cmd_d   = c1_in;
          tag_d   = a1_in;
          off_d   = '0;
          wlo_d   = d1_in;
          state_d = ST_ADDR2;
        end
      end
      ST_ADDR2: begin
        off_d   = a1_in[OFFSET_W-1:0];
        whi_d   = d1_in;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_valid) begin
          rdata_d = resp_rdata;
          state_d = ST_RESP1;
        end
      end
      ST_RESP1: state_d = (cmd_q == CTR1_W'(CMD_READ32)) ? ST_RESP2 : ST_RELEASE;
      ST_RESP2: state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    in_resp_d   = (state_d == ST_RESP1) || (state_d == ST_RESP2);
    req_valid_d = (state_d == ST_REQ);
    c1_oe_d     = (state_d == ST_REQ) || (state_d == ST_WAIT) || in_resp_d;
    c1_out_d    = in_resp_d ? CTR1_W'(CMD_RESPONSE) : CTR1_W'(CMD_NOP);
    d1_oe_d     = in_resp_d && cmd_is_read;
    d1_out_d    = '0;
    if (d1_oe_d) begin
      // First beat reads the freshly captured word; second beat the stored high half.
      d1_out_d = (state_d == ST_RESP1) ? rdata_d[DATA1_W-1:0]
                                       : rdata_q[WDATA_W-1:DATA1_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      tag_q     <= '0;
      off_q     <= '0;
      wlo_q     <= '0;
      whi_q     <= '0;
      rdata_q   <= '0;
      d1_out    <= '0;
      d1_oe     <= 1'b0;
      c1_out    <= CTR1_W'(CMD_NOP);
      c1_oe     <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      tag_q     <= tag_d;
      off_q     <= off_d;
      wlo_q     <= wlo_d;
      whi_q     <= whi_d;
      rdata_q   <= rdata_d;
      d1_out    <= d1_out_d;
      d1_oe     <= d1_oe_d;
      c1_out    <= c1_out_d;
      c1_oe     <= c1_oe_d;
      req_valid <= req_valid_d;
    end
  end

  assign req_cmd   = cmd_q;
  assign req_addr  = {tag_q, off_q};
  assign req_wdata = {whi_q, wlo_q};

endmodule

// File: tb/tb_cache_bus1_frontend.sv
// Directed bench for cache_bus1_frontend: bus command decode, core handshake and response beats.
module tb_cache_bus1_frontend;
  import cache_bus_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned OW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   a1_in;
  logic [DW-1:0]   d1_in;
  logic [CW-1:0]   c1_in;
  logic [DW-1:0]   d1_out;
  logic            d1_oe;
  logic [CW-1:0]   c1_out;
  logic            c1_oe;
  logic            req_valid;
  logic            req_ready;
  logic [CW-1:0]   req_cmd;
  logic [AW+OW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic            resp_valid;
  logic [2*DW-1:0] resp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_bus1_frontend #(.ADDR1_W(AW), .OFFSET_W(OW), .DATA1_W(DW), .CTR1_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .a1_in(a1_in), .d1_in(d1_in), .c1_in(c1_in),
    .d1_out(d1_out), .d1_oe(d1_oe), .c1_out(c1_out), .c1_oe(c1_oe),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives the two bus cycles of a command; returns with the DUT in REQ.
  task automatic issue(input logic [CW-1:0] cmd, input logic [AW-1:0] a,
                       input logic [DW-1:0] lo, input logic [OW-1:0] off,
                       input logic [DW-1:0] hi);
    c1_in = cmd; a1_in = a; d1_in = lo;
    cyc();
    c1_in = 3'd0; a1_in = AW'(off); d1_in = hi;
    cyc();
    a1_in = '0; d1_in = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; a1_in = '0; d1_in = '0; c1_in = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    #12;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got c1_oe=%b d1_oe=%b want 0 0", c1_oe, d1_oe); end
    checks++; if (c1_out !== 3'd0 || d1_out !== 16'h0) begin errors++; $display("FAIL reset_bus_out: got c1=%h d1=%h want 0 0", c1_out, d1_out); end
    checks++; if (req_cmd !== 3'd0 || req_addr !== 18'h0 || req_wdata !== 32'h0) begin errors++; $display("FAIL reset_req_fields: got cmd=%h addr=%h wdata=%h want 0", req_cmd, req_addr, req_wdata); end
    #5 reset_n = 1'b1;
    cyc();
    checks++; if (req_valid !== 1'b0 || c1_oe !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got req_valid=%b c1_oe=%b want 0 0", req_valid, c1_oe); end
  endtask

  task automatic test_read8();
    issue(3'd1, 14'h0123, 16'h0, 4'h5, 16'h0);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL read8_req_valid: got %b want 1", req_valid); end
    checks++; if (req_addr !== 18'h01235) begin errors++; $display("FAIL read8_addr: got %h want 01235", req_addr); end
    checks++; if (req_cmd !== 3'd1 || c1_oe !== 1'b1 || c1_out !== 3'd0) begin errors++; $display("FAIL read8_req_bus: got cmd=%h c1_oe=%b c1=%h want 1 1 0", req_cmd, c1_oe, c1_out); end
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0 || c1_oe !== 1'b1 || d1_oe !== 1'b0) begin errors++; $display("FAIL read8_wait: got req_valid=%b c1_oe=%b d1_oe=%b want 0 1 0", req_valid, c1_oe, d1_oe); end
    cyc(); cyc();
    resp_valid = 1'b1; resp_rdata = 32'h000000AB;
    cyc();
    resp_valid = 1'b0; resp_rdata = '0;
    checks++; if (c1_out !== 3'd7 || d1_oe !== 1'b1 || d1_out !== 16'h00AB) begin errors++; $display("FAIL read8_beat: got c1=%h d1_oe=%b d1=%h want 7 1 00ab", c1_out, d1_oe, d1_out); end
    cyc();
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0) begin errors++; $display("FAIL read8_release: got c1_oe=%b d1_oe=%b want 0 0", c1_oe, d1_oe); end
    cyc();
  endtask

  task automatic test_read32();
    issue(3'd3, 14'h0456, 16'h0, 4'hA, 16'h0);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
    cyc();
    resp_valid = 1'b0; resp_rdata = '0;
    checks++; if (c1_out !== 3'd7 || d1_oe !== 1'b1 || d1_out !== 16'hBEEF) begin errors++; $display("FAIL read32_beat1: got c1=%h d1_oe=%b d1=%h want 7 1 beef", c1_out, d1_oe, d1_out); end
    cyc();
    checks++; if (c1_out !== 3'd7 || d1_oe !== 1'b1 || d1_out !== 16'hDEAD) begin errors++; $display("FAIL read32_beat2: got c1=%h d1_oe=%b d1=%h want 7 1 dead", c1_out, d1_oe, d1_out); end
    cyc();
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0) begin errors++; $display("FAIL read32_release: got c1_oe=%b d1_oe=%b want 0 0", c1_oe, d1_oe); end
    cyc();
  endtask

  task automatic test_write32();
    issue(3'd7, 14'h0789, 16'h5678, 4'h3, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_valid !== 1'b1 || req_wdata !== 32'h12345678) begin errors++; $display("FAIL write32_hold%0d: got req_valid=%b wdata=%h want 1 12345678", i, req_valid, req_wdata); end
      cyc();
    end
    checks++; if (req_addr !== 18'h07893 || req_cmd !== 3'd7) begin errors++; $display("FAIL write32_fields: got addr=%h cmd=%h want 07893 7", req_addr, req_cmd); end
    // Completion offered together with acceptance must be ignored.
    req_ready = 1'b1; resp_valid = 1'b1; cyc();
    req_ready = 1'b0; resp_valid = 1'b0;
    checks++; if (c1_out !== 3'd0 || c1_oe !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL write32_same_cycle_resp: got c1=%h c1_oe=%b req_valid=%b want 0 1 0", c1_out, c1_oe, req_valid); end
    cyc();
    checks++; if (c1_out !== 3'd0 || c1_oe !== 1'b1) begin errors++; $display("FAIL write32_still_wait: got c1=%h c1_oe=%b want 0 1", c1_out, c1_oe); end
    resp_valid = 1'b1; cyc(); resp_valid = 1'b0;
    checks++; if (c1_out !== 3'd7 || c1_oe !== 1'b1 || d1_oe !== 1'b0) begin errors++; $display("FAIL write32_resp: got c1=%h c1_oe=%b d1_oe=%b want 7 1 0", c1_out, c1_oe, d1_oe); end
    cyc();
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0) begin errors++; $display("FAIL write32_release: got c1_oe=%b d1_oe=%b want 0 0", c1_oe, d1_oe); end
    cyc();
  endtask

  task automatic test_inv_line();
    c1_in = 3'd4; a1_in = 14'h3FFF; d1_in = 16'h9999;
    cyc();
    c1_in = 3'd0; a1_in = '0; d1_in = '0;
    checks++; if (req_valid !== 1'b1 || req_addr !== 18'h3FFF0 || req_cmd !== 3'd4) begin errors++; $display("FAIL inv_req: got valid=%b addr=%h cmd=%h want 1 3fff0 4", req_valid, req_addr, req_cmd); end
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    resp_valid = 1'b1; cyc(); resp_valid = 1'b0;
    checks++; if (c1_out !== 3'd7 || d1_oe !== 1'b0) begin errors++; $display("FAIL inv_resp: got c1=%h d1_oe=%b want 7 0", c1_out, d1_oe); end
    cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    issue(3'd2, 14'h0111, 16'h0, 4'h1, 16'h0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0 || c1_oe !== 1'b0 || req_addr !== 18'h0) begin errors++; $display("FAIL rst_in_req: got valid=%b c1_oe=%b addr=%h want 0 0 0", req_valid, c1_oe, req_addr); end
    #2 reset_n = 1'b1;
    cyc();
    issue(3'd2, 14'h0111, 16'h0, 4'h1, 16'h0);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0 || c1_out !== 3'd0 || req_valid !== 1'b0) begin errors++; $display("FAIL rst_in_wait: got c1_oe=%b d1_oe=%b c1=%h valid=%b want 0 0 0 0", c1_oe, d1_oe, c1_out, req_valid); end
    #2 reset_n = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'h0000FFFF;
    cyc();
    resp_valid = 1'b0; resp_rdata = '0;
    cyc();
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0 || c1_out !== 3'd0) begin errors++; $display("FAIL rst_late_resp: got c1_oe=%b d1_oe=%b c1=%h want 0 0 0", c1_oe, d1_oe, c1_out); end
    issue(3'd2, 14'h0222, 16'h0, 4'h2, 16'h0);
    checks++; if (req_valid !== 1'b1 || req_addr !== 18'h02222) begin errors++; $display("FAIL read16_req: got valid=%b addr=%h want 1 02222", req_valid, req_addr); end
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'h0000CAFE; cyc();
    resp_valid = 1'b0; resp_rdata = '0;
    checks++; if (c1_out !== 3'd7 || d1_oe !== 1'b1 || d1_out !== 16'hCAFE) begin errors++; $display("FAIL read16_beat: got c1=%h d1_oe=%b d1=%h want 7 1 cafe", c1_out, d1_oe, d1_out); end
    cyc();
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0) begin errors++; $display("FAIL read16_release: got c1_oe=%b d1_oe=%b want 0 0", c1_oe, d1_oe); end
    cyc();
  endtask

  task automatic test_spurious();
    issue(3'd1, 14'h0333, 16'h0, 4'h7, 16'h0);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    c1_in = 3'd1; a1_in = 14'h3ABC; d1_in = 16'hFFFF;
    cyc(); cyc();
    checks++; if (c1_out !== 3'd0 || c1_oe !== 1'b1 || d1_oe !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL spur_wait_bus: got c1=%h c1_oe=%b d1_oe=%b valid=%b want 0 1 0 0", c1_out, c1_oe, d1_oe, req_valid); end
    checks++; if (req_addr !== 18'h03337 || req_cmd !== 3'd1) begin errors++; $display("FAIL spur_wait_fields: got addr=%h cmd=%h want 03337 1", req_addr, req_cmd); end
    c1_in = 3'd0; a1_in = '0; d1_in = '0;
    resp_valid = 1'b1; resp_rdata = 32'h00000011; cyc();
    resp_valid = 1'b0; resp_rdata = '0;
    checks++; if (d1_out !== 16'h0011 || d1_oe !== 1'b1) begin errors++; $display("FAIL spur_resp: got d1=%h d1_oe=%b want 0011 1", d1_out, d1_oe); end
    cyc(); cyc();
    resp_valid = 1'b1; resp_rdata = 32'h00005555;
    cyc(); cyc();
    resp_valid = 1'b0; resp_rdata = '0;
    checks++; if (c1_oe !== 1'b0 || d1_oe !== 1'b0 || req_valid !== 1'b0 || c1_out !== 3'd0) begin errors++; $display("FAIL idle_resp_ignored: got c1_oe=%b d1_oe=%b valid=%b c1=%h want 0 0 0 0", c1_oe, d1_oe, req_valid, c1_out); end
  endtask

  initial begin
    test_reset();
    test_read8();
    test_read32();
    test_write32();
    test_inv_line();
    test_reset_mid();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/cache_bus1_frontend.md
CACHE_BUS1_FRONTEND -- requirements
Module: cache_bus1_frontend

Interface
REQ-001 Parameter ADDR1_W, default 14, SHALL set the tag+set width carried on a1 in the first bus cycle.
REQ-002 Parameter OFFSET_W, default 4, SHALL set the in-line byte-offset width carried on a1 in the second bus cycle.
REQ-003 Parameter DATA1_W, default 16, SHALL set the d1 width.
REQ-004 Parameter CTR1_W, default 3, SHALL set the c1 width.
REQ-005 Port list SHALL be, one per line:
  clk  in  1  single clock, rising edge active
  reset_n  in  1  asynchronous reset, active-low
  a1_in  in  ADDR1_W  bus1 address lines
  d1_in  in  DATA1_W  bus1 data lines, as driven by the master
  c1_in  in  CTR1_W  bus1 command lines, as driven by the master
  d1_out / d1_oe  out  DATA1_W / 1  slave data drive and its enable
  c1_out / c1_oe  out  CTR1_W / 1  slave command drive and its enable
  req_valid / req_ready  out / in  1 / 1  cache-core request handshake
  req_cmd  out  CTR1_W  latched command code
  req_addr  out  ADDR1_W+OFFSET_W  {tag+set, offset}
  req_wdata  out  2*DATA1_W  write data, {high beat, low beat}
  resp_valid  in  1  core completion pulse
  resp_rdata  in  2*DATA1_W  core read data, right-aligned

Function
REQ-006 Command codes SHALL be: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7; RESPONSE=7 when driven by the slave.
REQ-007 FSM states SHALL be IDLE, ADDR2, REQ, WAIT, RESP1, RESP2, RELEASE.
REQ-008 IDLE: c1_in==NOP -> stay; INV_LINE -> latch a1_in as tag+set, zero the offset, go to REQ; any other code -> latch c1_in, a1_in, and d1_in as low beat, go to ADDR2.
REQ-009 ADDR2: latch a1_in[OFFSET_W-1:0] as offset and d1_in as high beat; go to REQ unconditionally.
REQ-010 For WRITE8/16, only the low-beat bits [7:0]/[15:0] SHALL be meaningful; req_wdata SHALL carry the unmasked latched beats.
REQ-011 REQ: req_valid=1 and held with all req_* stable until req_ready=1; on that cycle go to WAIT.
REQ-012 WAIT: resp_valid=1 -> latch resp_rdata, go to RESP1; resp_valid SHALL be ignored in every other state.
REQ-013 RESP1: c1_out=RESPONSE; for reads d1_oe=1 and d1_out=low DATA1_W bits of the latched data; next is RESP2 for READ32, otherwise RELEASE.
REQ-014 RESP2: c1_out=RESPONSE, d1_out=high DATA1_W bits, d1_oe=1; go to RELEASE.
REQ-015 RELEASE: c1_oe=0, d1_oe=0; go to IDLE. One turnaround cycle SHALL always separate responses from the next command.
REQ-016 c1_oe SHALL be 1 from REQ through RESP2, with c1_out=NOP in REQ and WAIT; d1_oe SHALL be 1 only in RESP1/RESP2 of reads.
REQ-017 c1_in, a1_in, and d1_in SHALL be ignored outside IDLE and ADDR2.
REQ-018 Latency: command at cycle T gives req_valid at T+2; req_ready at cycle R gives WAIT at R+1; resp_valid at cycle W gives the first RESPONSE beat at W+1.
REQ-019 resp_valid on the same cycle that req_ready is accepted SHALL be ignored (the request is not yet in WAIT).

Reset
REQ-020 reset_n=0 SHALL asynchronously force IDLE and set c1_oe=0, d1_oe=0, req_valid=0, c1_out=NOP, d1_out=0, and req_cmd/req_addr/req_wdata=0.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no response beat; the core SHALL see req_valid fall asynchronously.

Structure
REQ-022 Command codes, the FSM state enum, and default widths SHALL live in the shared package cache_bus_pkg, alongside the existing bus-size constants.
REQ-023 No sub-module; tristate resolution SHALL stay at the top-level bus wrapper.

Verification
REQ-024 READ8 with a1=0x0123, then offset 0x5, core response 0x000000AB after 3 WAIT cycles -> req_addr=0x1235; one RESPONSE beat with d1=0x00AB; then RELEASE.
REQ-025 READ32 with resp_rdata=0xDEADBEEF -> beat 1 d1=0xBEEF, beat 2 d1=0xDEAD, each with c1=7; then both oe=0.
REQ-026 WRITE32 with low beat 0x5678, high beat 0x1234, req_ready held 0 for 4 cycles -> req_wdata=0x12345678 stable throughout; one RESPONSE with d1_oe=0.
REQ-027 INV_LINE with a1=0x3FFF -> req_addr=0x3FFF0 at T+1; no ADDR2 cycle.
REQ-028 reset_n pulsed low in WAIT -> all oe=0 and req_valid=0 immediately; a later resp_valid is ignored; the next READ16 completes normally.
REQ-029 Spurious c1_in=READ8 during WAIT, and resp_valid asserted in IDLE -> no state change and no bus drive.
